entities_line_renderer: RTL and testbench

Consumer side of the entity list: reads 21-bit entity records from the entity memory and turns them into per-pixel sprite hits for the display scan. Each line, it evaluates the list against the next line's y and collects up to MAX_SLOTS overlapping entities into a slot set. While one line is evaluated, the previous result drives the pixel output. Sits between the entity memory read port and the VGA colour stage.

---
 rtl/entities_line_renderer.sv | 215 +++++++++++++++++++++
 tb/tb_entities_line_renderer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/entities_line_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : entities_line_renderer
//  Purpose  : Reads entity records from the entity memory once per line,
//             collects up to MAX_SLOTS entities that overlap the next line's y
//             into an "eval" slot set, and paints sprite hits for the current
//             line from the previously collected "active" slot set.
//  Ports    :
//    clk              system clock, rising edge
//    reset            asynchronous, active-high
//    line_start       1-cycle pulse: swap slot sets, start evaluating next_line_y
//    next_line_y      line to evaluate (sampled with line_start)
//    entities_number  number of valid records (sampled with line_start)
//    address_read_ent entity memory read address
//    data_read_ent    record {type[20:18], y[17:9], x[8:0]}, one cycle after address
//    pixel_x          current pixel column
//    pixel_hit        registered: an active entity covers pixel_x
//    pixel_type       registered: type of the top-most covering entity
//    overflow         active set dropped entities
//    eval_busy        evaluation in progress
//    eval_late        1-cycle pulse: line_start arrived during an evaluation
//  Revision : 1.0  initial release
// ============================================================================
module entities_line_renderer #(
    parameter int MAX_SLOTS = 8,
    parameter int ENT_SIZE  = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic [8:0]  next_line_y,
    input  logic [7:0]  entities_number,
    output logic [7:0]  address_read_ent,
    input  logic [20:0] data_read_ent,
    input  logic [8:0]  pixel_x,
    output logic        pixel_hit,
    output logic [2:0]  pixel_type,
    output logic        overflow,
    output logic        eval_busy,
    output logic        eval_late
);

    localparam int                 c_CNT_W   = $clog2(MAX_SLOTS + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_SLOTS);
    localparam logic [9:0]         c_SIZE    = 10'(ENT_SIZE);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_FETCH = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic               w_busy;

    logic [7:0]         r_addr;
    logic [7:0]         r_idx;      // index of the record currently on data_read_ent
    logic               r_vld;      // data_read_ent holds a record for r_idx
    logic [7:0]         r_num;
    logic [8:0]         r_line_y;

    logic [c_CNT_W-1:0] r_eval_cnt;
    logic               r_eval_ovf;
    logic [8:0]         r_eval_x [MAX_SLOTS];
    logic [2:0]         r_eval_t [MAX_SLOTS];

    logic [c_CNT_W-1:0] r_act_cnt;
    logic               r_act_ovf;
    logic [8:0]         r_act_x  [MAX_SLOTS];
    logic [2:0]         r_act_t  [MAX_SLOTS];

    logic               r_pixel_hit;
    logic [2:0]         r_pixel_type;
    logic               r_late;

    logic [9:0]         w_rec_y;
    logic [9:0]         w_line_y;
    logic               w_match;
    logic               w_last;
    logic               w_hit;
    logic [2:0]         w_type;

    // Range tests are done in 10 bits so y+ENT_SIZE never wraps past 511.
    assign w_rec_y  = {1'b0, data_read_ent[17:9]};
    assign w_line_y = {1'b0, r_line_y};
    assign w_match  = w_busy && r_vld && (w_rec_y <= w_line_y) && (w_line_y < w_rec_y + c_SIZE);
    assign w_last   = w_busy && r_vld && (r_idx == r_num - 8'd1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (line_start && entities_number != 8'd0) begin
                    w_next_state = c_FETCH;
                end
            end
            c_FETCH: begin
                if (line_start) begin
                    w_next_state = (entities_number != 8'd0) ? c_FETCH : c_IDLE;
                end else if (w_last) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_busy = (r_state == c_FETCH);
    end

    // ---------------- fetch / evaluation control ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr     <= 8'd0;
            r_idx      <= 8'd0;
            r_vld      <= 1'b0;
            r_num      <= 8'd0;
            r_line_y   <= 9'd0;
            r_eval_cnt <= '0;
            r_eval_ovf <= 1'b0;
            r_act_cnt  <= '0;
            r_act_ovf  <= 1'b0;
        end else if (line_start) begin
            // An aborted evaluation must not be displayed: hand over an empty set.
            if (w_busy) begin
                r_act_cnt <= '0;
                r_act_ovf <= 1'b0;
            end else begin
                r_act_cnt <= r_eval_cnt;
                r_act_ovf <= r_eval_ovf;
            end
            r_eval_cnt <= '0;
            r_eval_ovf <= 1'b0;
            r_line_y   <= next_line_y;
            r_num      <= entities_number;
            r_addr     <= 8'd0;
            r_idx      <= 8'd0;
            r_vld      <= 1'b0;
        end else if (w_busy) begin
            r_vld <= 1'b1;
            r_idx <= r_addr;
            if (r_addr != r_num - 8'd1) begin
                r_addr <= r_addr + 8'd1;
            end
            if (w_match) begin
                if (r_eval_cnt < c_MAX_CNT) begin
                    r_eval_cnt <= r_eval_cnt + c_CNT_W'(1);
                end else begin
                    r_eval_ovf <= 1'b1;
                end
            end
        end
    end

    // Slot payloads need no reset: the counts decide which slots are valid.
    generate
        for (genvar s = 0; s < MAX_SLOTS; s++) begin : g_slot
            always_ff @(posedge clk) begin
                if (line_start) begin
                    r_act_x[s] <= r_eval_x[s];
                    r_act_t[s] <= r_eval_t[s];
                end else if (w_match && (r_eval_cnt == c_CNT_W'(s))) begin
                    r_eval_x[s] <= data_read_ent[8:0];
                    r_eval_t[s] <= data_read_ent[20:18];
                end
            end
        end
    endgenerate

    // ---------------- pixel stage ----------------
    // Later slots hold higher entity indices and are painted on top.
    always_comb begin
        w_hit  = 1'b0;
        w_type = 3'd0;
        for (int s = 0; s < MAX_SLOTS; s++) begin
            if ((c_CNT_W'(s) < r_act_cnt) &&
                ({1'b0, r_act_x[s]} <= {1'b0, pixel_x}) &&
                ({1'b0, pixel_x} < {1'b0, r_act_x[s]} + c_SIZE)) begin
                w_hit  = 1'b1;
                w_type = r_act_t[s];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pixel_hit  <= 1'b0;
            r_pixel_type <= 3'd0;
            r_late       <= 1'b0;
        end else begin
            r_pixel_hit  <= w_hit;
            r_pixel_type <= w_type;
            r_late       <= line_start && w_busy;
        end
    end

    assign address_read_ent = r_addr;
    assign pixel_hit        = r_pixel_hit;
    assign pixel_type       = r_pixel_type;
    assign overflow         = r_act_ovf;
    assign eval_busy        = w_busy;
    assign eval_late        = r_late;

endmodule
`default_nettype wire

// File: tb/tb_entities_line_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_entities_line_renderer
//  Purpose  : Self-checking bench for entities_line_renderer. A queue-based
//             reference model computes each line's slot set from the entity
//             list; pixel probes push expected values into a scoreboard that
//             a separate monitor drains as the DUT produces pixel outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_entities_line_renderer;

    localparam int c_SLOTS = 8;
    localparam int c_ENT   = 48;

    logic        clk = 1'b0;
    logic        reset;
    logic        line_start;
    logic [8:0]  next_line_y;
    logic [7:0]  entities_number;
    logic [7:0]  address_read_ent;
    logic [20:0] data_read_ent;
    logic [8:0]  pixel_x;
    logic        pixel_hit;
    logic [2:0]  pixel_type;
    logic        overflow;
    logic        eval_busy;
    logic        eval_late;

    always #5 clk = ~clk;

    entities_line_renderer #(.MAX_SLOTS(c_SLOTS), .ENT_SIZE(c_ENT)) u_dut (
        .clk              (clk),
        .reset            (reset),
        .line_start       (line_start),
        .next_line_y      (next_line_y),
        .entities_number  (entities_number),
        .address_read_ent (address_read_ent),
        .data_read_ent    (data_read_ent),
        .pixel_x          (pixel_x),
        .pixel_hit        (pixel_hit),
        .pixel_type       (pixel_type),
        .overflow         (overflow),
        .eval_busy        (eval_busy),
        .eval_late        (eval_late)
    );

    // Entity memory with a registered read port.
    logic [20:0] mem [256];
    always @(posedge clk) data_read_ent <= mem[address_read_ent];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int act_x[$], act_t[$];
    bit act_ovf = 0;
    int pend_x[$], pend_t[$];
    bit pend_ovf = 0;
    bit m_busy = 0;

    // Entities overlapping line ly, in index order; at most c_SLOTS are kept.
    task automatic model_eval(input int ly, input int n);
        pend_x.delete();
        pend_t.delete();
        pend_ovf = 0;
        for (int i = 0; i < n; i++) begin
            int ey;
            ey = int'(mem[i][17:9]);
            if (ey <= ly && ly < ey + c_ENT) begin
                if (pend_x.size() < c_SLOTS) begin
                    pend_x.push_back(int'(mem[i][8:0]));
                    pend_t.push_back(int'(mem[i][20:18]));
                end else begin
                    pend_ovf = 1;
                end
            end
        end
    endtask

    function automatic logic [3:0] exp_pixel(input int px);
        logic [3:0] r;
        r = 4'd0;
        foreach (act_x[k]) begin
            if (act_x[k] <= px && px < act_x[k] + c_ENT) r = {1'b1, 3'(act_t[k])};
        end
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    logic [3:0] exp_q[$];
    int         px_q[$];
    logic       probe = 1'b0;
    logic       probe_q = 1'b0;

    always @(posedge clk) probe_q <= probe;

    always @(negedge clk) begin
        if (probe_q) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: DUT output with no expected entry");
            end else begin
                logic [3:0] e;
                int p;
                e = exp_q.pop_front();
                p = px_q.pop_front();
                check($sformatf("pixel_hit@x%0d", p), 32'(pixel_hit), 32'(e[3]));
                check($sformatf("pixel_type@x%0d", p), 32'(pixel_type), 32'(e[2:0]));
            end
        end
    end

    task automatic scan(input int px);
        @(posedge clk); #1;
        pixel_x = 9'(px);
        probe   = 1'b1;
        exp_q.push_back(exp_pixel(px));
        px_q.push_back(px);
    endtask

    task automatic scan_end();
        @(posedge clk); #1;
        probe = 1'b0;
        @(posedge clk); #1;
    endtask

    // Issue line_start; optionally wait for the evaluation to finish.
    task automatic do_line(input int ly, input int n, input bit wait_done);
        bit late_exp;
        int edges;
        @(posedge clk); #1;
        line_start      = 1'b1;
        next_line_y     = 9'(ly);
        entities_number = 8'(n);
        late_exp = m_busy;
        if (m_busy) begin
            act_x.delete(); act_t.delete(); act_ovf = 0;
        end else begin
            act_x = pend_x; act_t = pend_t; act_ovf = pend_ovf;
        end
        model_eval(ly, n);
        m_busy = (n != 0);
        @(posedge clk); #1;
        line_start      = 1'b0;
        entities_number = 8'($urandom);
        check("eval_late", 32'(eval_late), 32'(late_exp));
        check("eval_busy_rise", 32'(eval_busy), 32'(n != 0));
        check("overflow", 32'(overflow), 32'(act_ovf));
        if (n != 0) check("addr_start", 32'(address_read_ent), 32'd0);
        if (wait_done) begin
            edges = 0;
            while (eval_busy === 1'b1 && edges < 1000) begin
                @(posedge clk); #1;
                edges++;
                if (edges == 1) check("eval_late_clear", 32'(eval_late), 32'd0);
            end
            check($sformatf("busy_edges_n%0d", n), 32'(edges), 32'((n == 0) ? 0 : n + 1));
            m_busy = 0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  32'(address_read_ent), 32'd0);
        check({tag, "_hit"},   32'(pixel_hit),        32'd0);
        check({tag, "_type"},  32'(pixel_type),       32'd0);
        check({tag, "_ovf"},   32'(overflow),         32'd0);
        check({tag, "_busy"},  32'(eval_busy),        32'd0);
        check({tag, "_late"},  32'(eval_late),        32'd0);
    endtask

    // Random list; dense_pct percent of entities are placed on line ly.
    task automatic fill_mem(input int ly, input int n, input int dense_pct);
        for (int i = 0; i < n; i++) begin
            int y, lo;
            lo = (ly > c_ENT - 1) ? ly - (c_ENT - 1) : 0;
            if (int'($urandom_range(99, 0)) < dense_pct) y = int'($urandom_range(ly, lo));
            else y = int'($urandom_range(511, 0));
            mem[i] = {3'($urandom), 9'(y), 9'($urandom)};
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 21'd0;
        reset = 1'b1; line_start = 1'b0; next_line_y = 9'd0;
        entities_number = 8'd0; pixel_x = 9'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // Empty lists
        do_line(0, 0, 1);
        do_line(0, 0, 1);
        for (int i = 0; i < 8; i++) scan(int'($urandom_range(511, 0)));
        scan_end();

        // Single entity {100, y=48, x=96}
        mem[0] = {3'b100, 9'd48, 9'd96};
        do_line(50, 1, 1);
        do_line(96, 1, 1);
        scan(96); scan(143); scan(95); scan(144); scan_end();
        do_line(47, 1, 1);
        scan(96); scan(120); scan_end();
        do_line(95, 1, 1);
        scan(96); scan(120); scan_end();
        do_line(0, 0, 1);
        scan(96); scan(143); scan(144); scan_end();

        // Priority: later index on top
        mem[0] = {3'b000, 9'd0, 9'd0};
        mem[1] = {3'b010, 9'd0, 9'd24};
        do_line(0, 2, 1);
        do_line(0, 0, 1);
        scan(10); scan(30); scan(71); scan(72); scan(0); scan_end();

        // Overflow: 10 entities on line 5
        for (int i = 0; i < 10; i++) mem[i] = {3'(i), 9'd5, 9'(48 * i)};
        do_line(5, 10, 1);
        for (int i = 3; i < 10; i++) mem[i][17:9] = 9'd200;
        do_line(5, 10, 1);
        scan(336); scan(383); scan(384); scan(400); scan(440); scan_end();
        do_line(0, 0, 1);
        scan(0); scan(100); scan(150); scan_end();

        // Randomised lines
        for (int r = 0; r < 6; r++) begin
            int ly, n;
            ly = int'($urandom_range(511, 0));
            n  = int'($urandom_range(40, 1));
            fill_mem(ly, n, 50);
            do_line(ly, n, 1);
            do_line(int'($urandom_range(511, 0)), 0, 1);
            for (int i = 0; i < 24; i++) scan(int'($urandom_range(511, 0)));
            foreach (act_x[k]) begin
                scan(act_x[k]);
                if (act_x[k] + c_ENT - 1 <= 511) scan(act_x[k] + c_ENT - 1);
            end
            scan_end();
        end

        // Late line_start
        fill_mem(200, 200, 40);
        do_line(200, 200, 0);
        repeat (49) @(posedge clk);
        do_line(200, 200, 1);
        for (int i = 0; i < 12; i++) scan(int'($urandom_range(511, 0)));
        scan_end();

        // Asynchronous reset mid-fetch, with a populated active set
        do_line(200, 200, 0);
        if (act_x.size() > 0) pixel_x = 9'(act_x[act_x.size() - 1]);
        else pixel_x = 9'd0;
        begin
            int edges;
            edges = 0;
            while (address_read_ent !== 8'd30 && edges < 100) begin
                @(posedge clk); #1;
                edges++;
            end
            check("addr_reach30", 32'(address_read_ent), 32'd30);
            check("pre_reset_hit", 32'(pixel_hit), 32'(exp_pixel(int'(pixel_x)) >> 3));
            #1;
            reset = 1'b1;
            #1;
            check_reset_outputs("async_reset");
            act_x.delete(); act_t.delete(); act_ovf = 0;
            pend_x.delete(); pend_t.delete(); pend_ovf = 0;
            m_busy = 0;
            @(posedge clk); #1;
            reset = 1'b0;
        end
        fill_mem(120, 5, 80);
        do_line(120, 5, 1);
        do_line(0, 0, 1);
        for (int i = 0; i < 12; i++) scan(int'($urandom_range(511, 0)));
        foreach (act_x[k]) scan(act_x[k]);
        scan_end();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
